pipeline_hazard_controller: RTL and testbench
=============================================

PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 Parameter MEM_TIMEOUT_CYCLES, default 64, SHALL set the number of consecutive MEM_WAIT cycles without mem_ack before the ERROR state is entered; legal range 2..65535.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset_n  input  1  synchronous, active-low reset.
REQ-004 id_rs1_address, id_rs2_address  input  5 each  source registers of the instruction in ID.
REQ-005 id_uses_rs1, id_uses_rs2  input  1 each  ID instruction reads rs1 / rs2.
REQ-006 ex_rd_address  input  5  destination register of the instruction in EX.
REQ-007 ex_is_load  input  1  EX instruction is a load.
REQ-008 ex_next_pc_src  input  2  EX control-flow select; any nonzero value means redirect (taken branch or jump).
REQ-009 mem_req  input  1  MEM stage holds a RAM access (load or store).
REQ-010 mem_ack  input  1  RAM completes the access this cycle.
REQ-011 pc_wren, if_id_wren, id_ex_wren, ex_mem_wren, mem_wb_wren  output  1 each  write enables of the PC and each pipeline register.
REQ-012 if_id_flush, id_ex_flush, mem_wb_flush  output  1 each  load a bubble (all-zero control fields) into that register; a flush SHALL only be asserted together with the same register's wren=1.
REQ-013 mem_timeout  output  1  sticky error flag.
REQ-014 stall_cycles, flush_events  output  32 each  performance counters (see Configuration).

Function
REQ-015 The FSM SHALL have three states: RUN, MEM_WAIT and ERROR; all outputs except the counters SHALL be combinational from the state and the current inputs.
REQ-016 Load-use hazard = ex_is_load & (ex_rd_address!=0) & ((id_uses_rs1 & rs1==ex_rd_address) | (id_uses_rs2 & rs2==ex_rd_address)).
REQ-017 RUN, default (no condition): all wren=1, all flush=0.
REQ-018 RUN, mem_req & !mem_ack: all wren=0 except mem_wb_wren=1 with mem_wb_flush=1; the next state SHALL be MEM_WAIT and the timeout count SHALL be cleared to 1.
REQ-019 RUN, mem_req & mem_ack in the same cycle: no stall; evaluation continues per REQ-020..022.
REQ-020 RUN, redirect (ex_next_pc_src!=0): all wren=1, if_id_flush=1, id_ex_flush=1; no load-use stall is applied in that cycle (the ID instruction is squashed).
REQ-021 RUN, load-use hazard without redirect: pc_wren=0, if_id_wren=0, id_ex_flush=1, other wren=1; the stall SHALL last exactly one cycle.
REQ-022 Priority, highest first: ERROR > memory wait > redirect > load-use.
REQ-023 MEM_WAIT, !mem_ack: outputs as in REQ-018; redirect and load-use SHALL be ignored; the count SHALL increment; when the count reaches MEM_TIMEOUT_CYCLES the next state SHALL be ERROR.
REQ-024 MEM_WAIT, mem_ack: outputs evaluated as in RUN with memory wait cleared (REQ-020/021 apply); the next state SHALL be RUN.
REQ-025 ERROR: all wren=0, all flush=0, mem_timeout=1; the FSM SHALL leave ERROR only by reset.

Reset
REQ-026 When reset_n=0 at a clk edge: state=RUN, timeout count=0, mem_timeout=0, stall_cycles=0, flush_events=0.
REQ-027 While reset_n=0 the combinational outputs SHALL be driven as RUN with all wren=1 and all flush=0, so that the pipeline registers reset themselves.
REQ-028 A reset asserted in MEM_WAIT or ERROR SHALL abort the wait with no residual stall in the following cycle.

Configuration
REQ-029 Macro HAZARD_PERF_COUNTERS_EN defined: stall_cycles SHALL increment in every cycle in which pc_wren=0; flush_events SHALL increment once per cycle in which if_id_flush or id_ex_flush is 1; both counters SHALL saturate at 0xFFFFFFFF.
REQ-030 Macro not defined: the counter registers SHALL be absent and stall_cycles and flush_events SHALL be tied to 0; the ports SHALL remain present.

Verification
REQ-031 Load at EX with rd=5, ID uses rs2=5 -> for 1 cycle pc_wren=0, if_id_wren=0, id_ex_flush=1; next cycle all wren=1; stall_cycles +1.
REQ-032 Load with rd=0 and ID rs1=0 -> no stall.
REQ-033 ex_next_pc_src=2 together with a load-use match -> if_id_flush=1, id_ex_flush=1, pc_wren=1; flush_events +1.
REQ-034 mem_req=1 and mem_ack arriving 3 cycles later -> 3 cycles of wren=0 with mem_wb_flush=1, then RUN; stall_cycles +3.
REQ-035 MEM_TIMEOUT_CYCLES=4 with mem_ack never asserted -> ERROR after the 4th wait cycle, mem_timeout=1 held, all wren=0; reset_n=0 for 1 cycle -> RUN, mem_timeout=0.
REQ-036 Repeat REQ-031 and REQ-033 without HAZARD_PERF_COUNTERS_EN -> identical control outputs, counters read 0.

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
// Hazard controller: load-use stall, redirect flush, memory wait and timeout.
// Optional perf counters enabled by defining HAZARD_PERF_COUNTERS_EN.
module pipeline_hazard_controller #(
  parameter int unsigned MEM_TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  id_rs1_address,
  input  logic [4:0]  id_rs2_address,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic [4:0]  ex_rd_address,
  input  logic        ex_is_load,
  input  logic [1:0]  ex_next_pc_src,
  input  logic        mem_req,
  input  logic        mem_ack,
  output logic        pc_wren,
  output logic        if_id_wren,
  output logic        id_ex_wren,
  output logic        ex_mem_wren,
  output logic        mem_wb_wren,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        mem_wb_flush,
  output logic        mem_timeout,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
);

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    ERROR
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        lu_q, lu_d;
  logic        load_use;
  logic        redirect;
  logic        wait_now;

  assign redirect = |ex_next_pc_src;

  assign load_use = ex_is_load && (ex_rd_address != 5'd0) &&
    ((id_uses_rs1 && (id_rs1_address == ex_rd_address)) ||
     (id_uses_rs2 && (id_rs2_address == ex_rd_address)));

  assign wait_now = (state_q == MEM_WAIT) ? !mem_ack
                                          : (mem_req && !mem_ack);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
      lu_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lu_q    <= lu_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lu_d         = 1'b0;
    pc_wren      = 1'b1;
    if_id_wren   = 1'b1;
    id_ex_wren   = 1'b1;
    ex_mem_wren  = 1'b1;
    mem_wb_wren  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    mem_timeout  = 1'b0;
    // In reset the outputs stay at the RUN defaults so the pipe clears itself
    if (reset_n) begin
      unique case (state_q)
        ERROR: begin
          pc_wren     = 1'b0;
          if_id_wren  = 1'b0;
          id_ex_wren  = 1'b0;
          ex_mem_wren = 1'b0;
          mem_wb_wren = 1'b0;
          mem_timeout = 1'b1;
        end
        default: begin
          if (wait_now) begin
            pc_wren      = 1'b0;
            if_id_wren   = 1'b0;
            id_ex_wren   = 1'b0;
            ex_mem_wren  = 1'b0;
            mem_wb_flush = 1'b1;
            if (state_q == RUN) begin
              state_d = MEM_WAIT;
              cnt_d   = 16'd1;
            end else begin
              cnt_d = cnt_q + 16'd1;
              if (32'(cnt_q) + 32'd1 >= MEM_TIMEOUT_CYCLES)
                state_d = ERROR;
            end
          end else begin
            state_d = RUN;
            if (redirect) begin
              if_id_flush = 1'b1;
              id_ex_flush = 1'b1;
            end else if (load_use && !lu_q) begin
              // The bubble moves the load on; never stall twice in a row
              pc_wren     = 1'b0;
              if_id_wren  = 1'b0;
              id_ex_flush = 1'b1;
              lu_d        = 1'b1;
            end
          end
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_COUNTERS_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (!pc_wren && (stall_cycles != 32'hFFFF_FFFF))
        stall_cycles <= stall_cycles + 32'd1;
      if ((if_id_flush || id_ex_flush) &&
          (flush_events != 32'hFFFF_FFFF))
        flush_events <= flush_events + 32'd1;
    end
  end
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller (timeout set to 4 cycles).
module tb_pipeline_hazard_controller;

`ifdef HAZARD_PERF_COUNTERS_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {pc,if_id,id_ex,ex_mem,mem_wb, if_id_fl,id_ex_fl,mem_wb_fl, timeout}
  localparam logic [8:0] C_RUN   = 9'b11111_000_0;
  localparam logic [8:0] C_MEMW  = 9'b00001_001_0;
  localparam logic [8:0] C_REDIR = 9'b11111_110_0;
  localparam logic [8:0] C_LU    = 9'b00111_010_0;
  localparam logic [8:0] C_ERR   = 9'b00000_000_1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  id_rs1_address, id_rs2_address, ex_rd_address;
  logic        id_uses_rs1, id_uses_rs2, ex_is_load;
  logic [1:0]  ex_next_pc_src;
  logic        mem_req, mem_ack;
  logic        pc_wren, if_id_wren, id_ex_wren, ex_mem_wren, mem_wb_wren;
  logic        if_id_flush, id_ex_flush, mem_wb_flush, mem_timeout;
  logic [31:0] stall_cycles, flush_events;
  logic [8:0]  ctl;

  int errors = 0;
  int checks = 0;
  int unsigned exp_stall = 0;
  int unsigned exp_flush = 0;

  pipeline_hazard_controller #(.MEM_TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .id_rs1_address(id_rs1_address), .id_rs2_address(id_rs2_address),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd_address(ex_rd_address), .ex_is_load(ex_is_load),
    .ex_next_pc_src(ex_next_pc_src),
    .mem_req(mem_req), .mem_ack(mem_ack),
    .pc_wren(pc_wren), .if_id_wren(if_id_wren), .id_ex_wren(id_ex_wren),
    .ex_mem_wren(ex_mem_wren), .mem_wb_wren(mem_wb_wren),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .mem_wb_flush(mem_wb_flush), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  always #5 clk = ~clk;

  assign ctl = {pc_wren, if_id_wren, id_ex_wren, ex_mem_wren, mem_wb_wren,
                if_id_flush, id_ex_flush, mem_wb_flush, mem_timeout};

  task automatic idle();
    id_rs1_address = '0; id_rs2_address = '0; ex_rd_address = '0;
    id_uses_rs1 = 0; id_uses_rs2 = 0; ex_is_load = 0;
    ex_next_pc_src = '0; mem_req = 0; mem_ack = 0;
  endtask

  // Advance one clock; the counter model follows the control the bench expects
  task automatic tick(input logic [8:0] e);
    if (!reset_n) begin
      exp_stall = 0;
      exp_flush = 0;
    end else begin
      if (!e[8]) exp_stall++;
      if (e[3] || e[2]) exp_flush++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 0;
    idle();
    mem_req = 1; ex_is_load = 1; ex_rd_address = 5'd3;
    id_uses_rs1 = 1; id_rs1_address = 5'd3; ex_next_pc_src = 2'd1;
    #1;
    checks++;
    if (ctl !== C_RUN) begin
      $display("FAIL reset_ctl got=%b want=%b", ctl, C_RUN); errors++;
    end
    tick(C_RUN);
    tick(C_RUN);
    reset_n = 1;
    idle();
    #1;
    checks++;
    if (ctl !== C_RUN) begin
      $display("FAIL post_reset_ctl got=%b want=%b", ctl, C_RUN); errors++;
    end
    checks++;
    if (stall_cycles !== 32'd0 || flush_events !== 32'd0) begin
      $display("FAIL reset_counters got=%0d/%0d want=0/0",
               stall_cycles, flush_events);
      errors++;
    end
  endtask

  task automatic test_load_use();
    idle();
    ex_is_load = 1; ex_rd_address = 5'd5;
    id_uses_rs2 = 1; id_rs2_address = 5'd5;
    #1;
    checks++;
    if (ctl !== C_LU) begin
      $display("FAIL lu_rs2 got=%b want=%b", ctl, C_LU); errors++;
    end
    tick(C_LU);
    checks++;
    if (ctl !== C_RUN) begin
      $display("FAIL lu_one_cycle got=%b want=%b", ctl, C_RUN); errors++;
    end
    tick(C_RUN);
    checks++;
    if (stall_cycles !== (PERF ? 32'(exp_stall) : 32'd0)) begin
      $display("FAIL lu_stall_cnt got=%0d want=%0d", stall_cycles,
               PERF ? exp_stall : 0);
      errors++;
    end
    idle();
    ex_is_load = 1; ex_rd_address = 5'd9;
    id_uses_rs1 = 1; id_rs1_address = 5'd9;
    #1;
    checks++;
    if (ctl !== C_LU) begin
      $display("FAIL lu_rs1 got=%b want=%b", ctl, C_LU); errors++;
    end
    tick(C_LU);
    idle();
    ex_is_load = 1; ex_rd_address = 5'd9;
    id_uses_rs1 = 0; id_rs1_address = 5'd9; id_rs2_address = 5'd9;
    #1;
    checks++;
    if (ctl !== C_RUN) begin
      $display("FAIL lu_unused got=%b want=%b", ctl, C_RUN); errors++;
    end
    tick(C_RUN);
    idle();
    ex_rd_address = 5'd7; id_uses_rs1 = 1; id_rs1_address = 5'd7;
    #1;
    checks++;
    if (ctl !== C_RUN) begin
      $display("FAIL lu_not_load got=%b want=%b", ctl, C_RUN); errors++;
    end
    tick(C_RUN);
    idle();
    ex_is_load = 1; ex_rd_address = 5'd0;
    id_uses_rs1 = 1; id_rs1_address = 5'd0;
    #1;
    checks++;
    if (ctl !== C_RUN) begin
      $display("FAIL lu_rd_zero got=%b want=%b", ctl, C_RUN); errors++;
    end
    tick(C_RUN);
  endtask

  task automatic test_redirect();
    idle();
    ex_next_pc_src = 2'd2;
    ex_is_load = 1; ex_rd_address = 5'd5;
    id_uses_rs2 = 1; id_rs2_address = 5'd5;
    #1;
    checks++;
    if (ctl !== C_REDIR) begin
      $display("FAIL redir_lu got=%b want=%b", ctl, C_REDIR); errors++;
    end
    tick(C_REDIR);
    idle();
    ex_next_pc_src = 2'd1;
    #1;
    checks++;
    if (ctl !== C_REDIR) begin
      $display("FAIL redir_plain got=%b want=%b", ctl, C_REDIR); errors++;
    end
    tick(C_REDIR);
    idle();
    #1;
    checks++;
    if (flush_events !== (PERF ? 32'(exp_flush) : 32'd0)) begin
      $display("FAIL redir_flush_cnt got=%0d want=%0d", flush_events,
               PERF ? exp_flush : 0);
      errors++;
    end
  endtask

  task automatic test_mem_wait();
    idle();
    mem_req = 1; mem_ack = 1;
    #1;
    checks++;
    if (ctl !== C_RUN) begin
      $display("FAIL mem_same_ack got=%b want=%b", ctl, C_RUN); errors++;
    end
    tick(C_RUN);
    mem_ack = 0;
    for (int i = 0; i < 3; i++) begin
      ex_next_pc_src = (i == 1) ? 2'd3 : 2'd0;
      #1;
      checks++;
      if (ctl !== C_MEMW) begin
        $display("FAIL mem_wait%0d got=%b want=%b", i, ctl, C_MEMW);
        errors++;
      end
      tick(C_MEMW);
    end
    ex_next_pc_src = 2'd0;
    mem_ack = 1;
    #1;
    checks++;
    if (ctl !== C_RUN) begin
      $display("FAIL mem_ack got=%b want=%b", ctl, C_RUN); errors++;
    end
    tick(C_RUN);
    idle();
    #1;
    checks++;
    if (ctl !== C_RUN) begin
      $display("FAIL mem_back_run got=%b want=%b", ctl, C_RUN); errors++;
    end
    checks++;
    if (stall_cycles !== (PERF ? 32'(exp_stall) : 32'd0)) begin
      $display("FAIL mem_stall_cnt got=%0d want=%0d", stall_cycles,
               PERF ? exp_stall : 0);
      errors++;
    end
    mem_req = 1;
    #1;
    tick(C_MEMW);
    mem_ack = 1; ex_next_pc_src = 2'd2;
    #1;
    checks++;
    if (ctl !== C_REDIR) begin
      $display("FAIL mem_ack_redir got=%b want=%b", ctl, C_REDIR); errors++;
    end
    tick(C_REDIR);
    idle();
    mem_req = 1;
    #1;
    tick(C_MEMW);
    tick(C_MEMW);
    reset_n = 0;
    #1;
    checks++;
    if (ctl !== C_RUN) begin
      $display("FAIL mem_in_reset got=%b want=%b", ctl, C_RUN); errors++;
    end
    tick(C_RUN);
    reset_n = 1;
    idle();
    #1;
    checks++;
    if (ctl !== C_RUN) begin
      $display("FAIL mem_reset_abort got=%b want=%b", ctl, C_RUN); errors++;
    end
    tick(C_RUN);
  endtask

  task automatic test_timeout();
    idle();
    mem_req = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (ctl !== C_MEMW) begin
        $display("FAIL tmo_wait%0d got=%b want=%b", i, ctl, C_MEMW);
        errors++;
      end
      tick(C_MEMW);
    end
    for (int i = 0; i < 3; i++) begin
      mem_ack = (i == 1);
      ex_next_pc_src = (i == 2) ? 2'd1 : 2'd0;
      #1;
      checks++;
      if (ctl !== C_ERR) begin
        $display("FAIL tmo_error%0d got=%b want=%b", i, ctl, C_ERR);
        errors++;
      end
      tick(C_ERR);
    end
    checks++;
    if (stall_cycles !== (PERF ? 32'(exp_stall) : 32'd0)) begin
      $display("FAIL tmo_stall_cnt got=%0d want=%0d", stall_cycles,
               PERF ? exp_stall : 0);
      errors++;
    end
    reset_n = 0;
    idle();
    #1;
    checks++;
    if (ctl !== C_RUN) begin
      $display("FAIL tmo_in_reset got=%b want=%b", ctl, C_RUN); errors++;
    end
    tick(C_RUN);
    reset_n = 1;
    #1;
    checks++;
    if (ctl !== C_RUN || mem_timeout !== 1'b0) begin
      $display("FAIL tmo_recover got=%b want=%b", ctl, C_RUN); errors++;
    end
    checks++;
    if (stall_cycles !== 32'd0 || flush_events !== 32'd0) begin
      $display("FAIL tmo_cnt_clear got=%0d/%0d want=0/0",
               stall_cycles, flush_events);
      errors++;
    end
    tick(C_RUN);
  endtask

  initial begin
    reset_n = 0;
    idle();
    test_reset();
    test_load_use();
    test_redirect();
    test_mem_wait();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
